// File: rtl/uart_tx_ctrl.sv
// UART transmitter: one byte per valid/ready handshake, LSB first, with its own
// baud counter driven by the run-time divisor; parity and stop bits fixed at build.
module uart_tx_ctrl #(
   parameter int DLY       = 0,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [12:0] uart_ctrl,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic        txd,
   output logic        tx_busy
);

   // DLY is a simulation-only delay and must not be negative.
   if (PARITY < 0 || PARITY >= 3 || (STOP_BITS != 1 && STOP_BITS != 2) || DLY < 0) begin : g_bad_param
      $error("uart_tx_ctrl: illegal PARITY/STOP_BITS/DLY parameter");
   end

   localparam logic HAS_PAR  = (PARITY != 0);
   localparam logic ODD_PAR  = (PARITY == 1);
   localparam logic TWO_STOP = (STOP_BITS == 2);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t      state_q, state_d;
   logic [12:0] cnt_q, cnt_d;
   logic [12:0] div_q, div_d;
   logic [7:0]  data_q, data_d;
   logic [2:0]  bit_q, bit_d;
   logic        stop_q, stop_d;
   logic        txd_q, txd_d;
   logic        busy_q, busy_d;
   logic        last_cyc;
   logic        last_stop;
   logic        accept;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      data_d    = data_q;
      bit_d     = bit_q;
      stop_d    = stop_q;
      last_cyc  = (cnt_q == div_q);
      last_stop = (state_q == STOP) && last_cyc && (stop_q == TWO_STOP);
      tx_ready  = (state_q == IDLE) || last_stop;
      accept    = tx_valid && tx_ready;

      if (accept) begin
         state_d = START;
         cnt_d   = 13'd0;
         div_d   = uart_ctrl;
         data_d  = tx_data;
         bit_d   = 3'd0;
         stop_d  = 1'b0;
      end else if (state_q != IDLE) begin
         if (last_cyc) begin
            cnt_d = 13'd0;
            case (state_q)
               START: begin
                  state_d = DATA;
                  bit_d   = 3'd0;
               end
               DATA: begin
                  if (bit_q == 3'd7) begin
                     state_d = HAS_PAR ? PAR : STOP;
                     stop_d  = 1'b0;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end
               PAR: begin
                  state_d = STOP;
                  stop_d  = 1'b0;
               end
               STOP: begin
                  if (stop_q == TWO_STOP) begin
                     state_d = IDLE;
                     bit_d   = 3'd0;
                  end else begin
                     stop_d = 1'b1;
                  end
               end
               default: state_d = IDLE;
            endcase
         end else begin
            cnt_d = cnt_q + 13'd1;
         end
      end

      // txd is registered, so it is computed from the state about to be entered.
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = data_d[bit_d];
         PAR:     txd_d = ODD_PAR ? ~(^data_d) : (^data_d);
         default: txd_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 13'd0;
         div_q   <= 13'd0;
         data_q  <= 8'd0;
         bit_q   <= 3'd0;
         stop_q  <= 1'b0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         data_q  <= data_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
      end
   end

   assign txd     = txd_q;
   assign tx_busy = busy_q;

endmodule
